// File: rtl/vin_srcsel.sv
// rtl/vin_srcsel.sv - multi-channel video input selector with activity monitor and FWFT FIFO
module vin_srcsel #(
    parameter int CHANNELS       = 2,
    parameter int PIXW           = 32,
    parameter int DEPTH          = 16,
    parameter int TIMEOUT        = 2000000,
    parameter int FLUSH_ON_VSYNC = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CHANNELS-1:0]          in_vsync,
    input  logic [CHANNELS-1:0]          in_valid,
    input  logic [CHANNELS*PIXW-1:0]     in_pixel,
    input  logic                         force_en,
    input  logic [$clog2(CHANNELS)-1:0]  force_sel,
    output logic                         out_vsync,
    output logic [PIXW-1:0]              out_pixel,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(CHANNELS)-1:0]  sel,
    output logic [CHANNELS-1:0]          active,
    output logic                         overflow
);

    localparam int SW = $clog2(CHANNELS);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic {LOCKED, PENDING} state_t;

    state_t              state, state_nx;
    logic [CHANNELS-1:0] vs_prev;
    logic [CHANNELS-1:0] vs_rise;
    logic [CHANNELS-1:0] seen;
    logic [CW-1:0]       cnt [CHANNELS];
    logic [SW-1:0]       target;
    logic                do_switch;
    logic                sel_valid;
    logic                sel_vsync;
    logic                sel_rise;
    logic                tgt_rise;
    logic [PIXW-1:0]     sel_pixel;
    logic                flush;
    logic                full;
    logic                pop;
    logic                wr_en;
    logic [PW-1:0]       wr_ptr, rd_ptr;
    logic [PIXW-1:0]     mem [DEPTH];

    assign vs_rise = in_vsync & ~vs_prev;

    // Previous vsync level per channel for rising-edge detection
    always_ff @(posedge clk) begin
        if (rst) vs_prev <= '0;
        else     vs_prev <= in_vsync;
    end

    // Activity monitor: two edges closer than TIMEOUT make a channel active, TIMEOUT idle cycles clear it
    always_ff @(posedge clk) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (rst) begin
                cnt[i]    <= '0;
                seen[i]   <= 1'b0;
                active[i] <= 1'b0;
            end else if (vs_rise[i]) begin
                cnt[i]  <= '0;
                seen[i] <= 1'b1;
                if (seen[i] && (cnt[i] < CW'(TIMEOUT)))
                    active[i] <= 1'b1;
            end else if (cnt[i] != CW'(TIMEOUT)) begin
                cnt[i] <= cnt[i] + CW'(1);
                if (cnt[i] == CW'(TIMEOUT - 1))
                    active[i] <= 1'b0;
            end
        end
    end

    // Desired source: forced channel (out-of-range maps to 0) or lowest active, else hold
    always_comb begin
        target = sel;
        if (force_en) begin
            target = (int'(force_sel) < CHANNELS) ? force_sel : '0;
        end else begin
            for (int i = CHANNELS - 1; i >= 0; i--)
                if (active[i]) target = SW'(i);
        end
    end

    // Per-channel muxes for the current source and the pending target
    always_comb begin
        sel_valid = 1'b0;
        sel_vsync = 1'b0;
        sel_rise  = 1'b0;
        sel_pixel = '0;
        tgt_rise  = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (sel == SW'(i)) begin
                sel_valid = in_valid[i];
                sel_vsync = in_vsync[i];
                sel_rise  = vs_rise[i];
                sel_pixel = in_pixel[i*PIXW +: PIXW];
            end
            if (target == SW'(i))
                tgt_rise = vs_rise[i];
        end
    end

    // Switch FSM: wait in PENDING for a frame start on the target, drop back if the target returns to sel
    always_comb begin
        state_nx  = state;
        do_switch = 1'b0;
        case (state)
            LOCKED: begin
                if (target != sel) state_nx = PENDING;
            end
            PENDING: begin
                if (target == sel) begin
                    state_nx = LOCKED;
                end else if (tgt_rise) begin
                    state_nx  = LOCKED;
                    do_switch = 1'b1;
                end
            end
            default: state_nx = LOCKED;
        endcase
    end

    // FSM state, selected source and registered output vsync
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LOCKED;
            sel       <= '0;
            out_vsync <= 1'b0;
        end else begin
            state     <= state_nx;
            out_vsync <= sel_vsync;
            if (do_switch) sel <= target;
        end
    end

    assign flush     = do_switch || ((FLUSH_ON_VSYNC != 0) && sel_rise);
    assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign out_valid = (wr_ptr != rd_ptr);
    assign pop       = out_valid && out_ready;
    assign wr_en     = sel_valid && (!full || pop) && !flush;
    assign out_pixel = mem[rd_ptr[AW-1:0]];

    // FIFO pointers and sticky overflow; a flush discards everything and masks push/pop
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (pop)   rd_ptr <= rd_ptr + PW'(1);
            if (sel_valid && full && !pop) overflow <= 1'b1;
        end
    end

    // FIFO storage, no reset needed since contents are qualified by the pointers
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= sel_pixel;
    end

endmodule

// File: tb/tb_vin_srcsel.sv
// tb/tb_vin_srcsel.sv - directed self-checking bench for vin_srcsel
module tb_vin_srcsel;

    localparam int CH = 3;
    localparam int PIXW = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [CH-1:0]     in_vsync = '0;
    logic [CH-1:0]     in_valid = '0;
    logic [CH*PIXW-1:0] in_pixel = '0;
    logic              force_en = 1'b0;
    logic [1:0]        force_sel = '0;
    logic              out_vsync;
    logic [PIXW-1:0]   out_pixel;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [1:0]        sel;
    logic [CH-1:0]     active;
    logic              overflow;

    int tests = 0;
    int failed = 0;

    vin_srcsel #(.CHANNELS(CH), .PIXW(PIXW), .DEPTH(16), .TIMEOUT(30), .FLUSH_ON_VSYNC(1)) dut (
        .clk(clk), .rst(rst), .in_vsync(in_vsync), .in_valid(in_valid), .in_pixel(in_pixel),
        .force_en(force_en), .force_sel(force_sel), .out_vsync(out_vsync), .out_pixel(out_pixel),
        .out_valid(out_valid), .out_ready(out_ready), .sel(sel), .active(active), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_vsync = '0; in_valid = '0; in_pixel = '0;
        force_en = 1'b0; force_sel = '0; out_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic push(input logic [31:0] w);
        in_valid = 3'b001;
        in_pixel[31:0] = w;
        step();
        in_valid = '0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (sel !== 2'd0) begin failed++; $display("FAIL reset_sel got %0d exp 0", sel); end
        tests++; if (active !== 3'b000) begin failed++; $display("FAIL reset_active got %b exp 000", active); end
        tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        tests++; if (out_vsync !== 1'b0) begin failed++; $display("FAIL reset_out_vsync got %b exp 0", out_vsync); end
        tests++; if (overflow !== 1'b0) begin failed++; $display("FAIL reset_overflow got %b exp 0", overflow); end
    endtask

    task automatic test_buffering();
        do_reset();
        for (int w = 0; w < 20; w++) begin
            in_valid = 3'b001;
            in_pixel[31:0] = w;
            step();
            if (w == 0) begin
                tests++; if (out_valid !== 1'b1 || out_pixel !== 32'd0) begin failed++;
                    $display("FAIL buf_first_latency got v=%b p=%0d exp v=1 p=0", out_valid, out_pixel); end
            end
        end
        in_valid = '0;
        tests++; if (overflow !== 1'b1) begin failed++; $display("FAIL buf_overflow got %b exp 1", overflow); end
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tests++; if (out_valid !== 1'b1 || out_pixel !== 32'(k)) begin failed++;
                $display("FAIL buf_drain[%0d] got v=%b p=%0d exp v=1 p=%0d", k, out_valid, out_pixel, k); end
            step();
        end
        tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL buf_empty_after_16 got %b exp 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_full_pushpop();
        do_reset();
        for (int w = 0; w < 16; w++) push(32'(w));
        tests++; if (overflow !== 1'b0) begin failed++; $display("FAIL pp_no_overflow_at_16 got %b exp 0", overflow); end
        out_ready = 1'b1;
        in_valid = 3'b001;
        in_pixel[31:0] = 32'd16;
        step();
        in_valid = '0;
        tests++; if (overflow !== 1'b0) begin failed++; $display("FAIL pp_push_pop_full got ovf=%b exp 0", overflow); end
        for (int k = 1; k <= 16; k++) begin
            tests++; if (out_valid !== 1'b1 || out_pixel !== 32'(k)) begin failed++;
                $display("FAIL pp_drain[%0d] got v=%b p=%0d exp v=1 p=%0d", k, out_valid, out_pixel, k); end
            step();
        end
        tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL pp_empty got %b exp 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_auto();
        do_reset();
        for (int c = 0; c <= 80; c++) begin
            in_vsync[0] = (c <= 41) && ((c % 10) < 2);
            in_vsync[1] = ((c % 10) == 5) || ((c % 10) == 6);
            in_valid = (c >= 60 && c <= 64) ? 3'b001 : 3'b000;
            in_pixel[31:0] = 32'(100 + c);
            step();
            if (c == 39) begin
                tests++; if (active !== 3'b011 || sel !== 2'd0) begin failed++;
                    $display("FAIL auto_both_active got act=%b sel=%0d exp act=011 sel=0", active, sel); end
            end
            if (c == 69) begin
                tests++; if (active[0] !== 1'b1) begin failed++; $display("FAIL auto_act0_before_timeout got %b exp 1", active[0]); end
            end
            if (c == 70) begin
                tests++; if (active !== 3'b010 || sel !== 2'd0) begin failed++;
                    $display("FAIL auto_act0_timeout got act=%b sel=%0d exp act=010 sel=0", active, sel); end
            end
            if (c == 74) begin
                tests++; if (sel !== 2'd0 || out_valid !== 1'b1 || out_pixel !== 32'd160) begin failed++;
                    $display("FAIL auto_pre_switch got sel=%0d v=%b p=%0d exp sel=0 v=1 p=160", sel, out_valid, out_pixel); end
            end
            if (c == 75) begin
                tests++; if (sel !== 2'd1 || out_valid !== 1'b0) begin failed++;
                    $display("FAIL auto_switch got sel=%0d v=%b exp sel=1 v=0", sel, out_valid); end
            end
        end
        in_vsync = '0; in_valid = '0;
    endtask

    task automatic test_forced();
        do_reset();
        force_en = 1'b1;
        force_sel = 2'd1;
        for (int i = 0; i < 4; i++) step();
        tests++; if (sel !== 2'd0) begin failed++; $display("FAIL force_wait got sel=%0d exp 0", sel); end
        in_vsync[1] = 1'b1;
        step();
        tests++; if (sel !== 2'd1 || out_vsync !== 1'b0) begin failed++;
            $display("FAIL force_switch got sel=%0d ovs=%b exp sel=1 ovs=0", sel, out_vsync); end
        step();
        tests++; if (out_vsync !== 1'b1) begin failed++; $display("FAIL force_out_vsync_follows got %b exp 1", out_vsync); end
        in_vsync[1] = 1'b0;
        force_sel = 2'd3;
        for (int i = 0; i < 3; i++) step();
        tests++; if (sel !== 2'd1) begin failed++; $display("FAIL force_oob_wait got sel=%0d exp 1", sel); end
        in_vsync[0] = 1'b1;
        step();
        tests++; if (sel !== 2'd0) begin failed++; $display("FAIL force_oob_to_0 got sel=%0d exp 0", sel); end
        in_vsync[0] = 1'b0;
        force_en = 1'b0;
        step();
    endtask

    task automatic test_cancel();
        do_reset();
        push(32'd200); push(32'd201); push(32'd202);
        force_en = 1'b1;
        force_sel = 2'd1;
        for (int i = 0; i < 3; i++) step();
        force_sel = 2'd0;
        step(); step();
        in_vsync[1] = 1'b1;
        step();
        in_vsync[1] = 1'b0;
        step();
        tests++; if (sel !== 2'd0 || out_valid !== 1'b1) begin failed++;
            $display("FAIL cancel_no_switch got sel=%0d v=%b exp sel=0 v=1", sel, out_valid); end
        force_en = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tests++; if (out_valid !== 1'b1 || out_pixel !== 32'(200 + k)) begin failed++;
                $display("FAIL cancel_intact[%0d] got v=%b p=%0d exp v=1 p=%0d", k, out_valid, out_pixel, 200 + k); end
            step();
        end
        tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL cancel_empty got %b exp 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_vsync_flush();
        do_reset();
        for (int w = 0; w < 17; w++) push(32'(300 + w));
        tests++; if (overflow !== 1'b1 || out_valid !== 1'b1) begin failed++;
            $display("FAIL vflush_setup got ovf=%b v=%b exp ovf=1 v=1", overflow, out_valid); end
        in_vsync[0] = 1'b1;
        in_valid = 3'b001;
        in_pixel[31:0] = 32'd999;
        step();
        tests++; if (out_valid !== 1'b0 || overflow !== 1'b1) begin failed++;
            $display("FAIL vflush_empty got v=%b ovf=%b exp v=0 ovf=1", out_valid, overflow); end
        in_pixel[31:0] = 32'd400;
        step();
        in_valid = '0;
        tests++; if (out_valid !== 1'b1 || out_pixel !== 32'd400) begin failed++;
            $display("FAIL vflush_next_word got v=%b p=%0d exp v=1 p=400", out_valid, out_pixel); end
        in_vsync[0] = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        in_vsync[0] = 1'b1;
        step();
        for (int w = 0; w < 17; w++) push(32'(500 + w));
        force_en = 1'b1;
        force_sel = 2'd1;
        step(); step();
        tests++; if (out_vsync !== 1'b1 || overflow !== 1'b1 || out_valid !== 1'b1) begin failed++;
            $display("FAIL rstmid_setup got ovs=%b ovf=%b v=%b exp 1 1 1", out_vsync, overflow, out_valid); end
        rst = 1'b1;
        step();
        tests++; if (sel !== 2'd0 || out_valid !== 1'b0 || out_vsync !== 1'b0 || overflow !== 1'b0 || active !== 3'b000) begin
            failed++;
            $display("FAIL rstmid_outputs got sel=%0d v=%b ovs=%b ovf=%b act=%b exp 0 0 0 0 000",
                     sel, out_valid, out_vsync, overflow, active);
        end
        rst = 1'b0;
        in_vsync = '0;
        force_en = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_buffering();
        test_full_pushpop();
        test_auto();
        test_forced();
        test_cancel();
        test_vsync_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
